// File: rtl/mux_sched_pkg.sv
// ----------------------------------------------------------------------------
// mux_sched_pkg
// Shared constants and state encoding for the round-robin mux scheduler.
//   N      : number of requesters (fixed to the 16:1 mux width)
//   SEL_W  : width of the mux select / requester index
//   state_e: scheduler FSM states (IDLE = no grant, BUSY = grant held)
// ----------------------------------------------------------------------------
package mux_sched_pkg;

    localparam int N     = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// ----------------------------------------------------------------------------
// mux_rr_scheduler_if
// Handshake and data bundle between the requesting channels and the scheduler.
//   req     : per-requester request, level-sensitive
//   rel     : release of the current grant by its owner
//   di      : data bits, bit k belongs to requester k
//   gnt     : one-hot grant
//   si      : binary index of the granted requester (mux select)
//   busy    : a grant is active
//   timeout : one-cycle pulse when a grant is cut off by the hold limit
//   y/y_vld : registered mux output and its valid flag
// Modports: master = requester side, slave = scheduler side.
// ----------------------------------------------------------------------------
interface mux_rr_scheduler_if;
    import mux_sched_pkg::*;

    logic [N-1:0]     req;
    logic             rel;
    logic [N-1:0]     di;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] si;
    logic             busy;
    logic             timeout;
    logic             y;
    logic             y_vld;

    modport master (
        output req, rel, di,
        input  gnt, si, busy, timeout, y, y_vld
    );

    modport slave (
        input  req, rel, di,
        output gnt, si, busy, timeout, y, y_vld
    );

endinterface

// File: rtl/mux_rr_scheduler_mux.sv
// ----------------------------------------------------------------------------
// mux_16x1
// Plain combinational 16:1 data-flow multiplexer.
//   d_i : 16 data inputs
//   s_i : 4-bit select
//   y_o : selected bit
// ----------------------------------------------------------------------------
module mux_16x1 (
    input  logic [15:0] d_i,
    input  logic [3:0]  s_i,
    output logic        y_o
);

    assign y_o = d_i[s_i];

endmodule

// File: rtl/mux_rr_scheduler.sv
// ----------------------------------------------------------------------------
// mux_rr_scheduler
// Round-robin scheduler sharing one 16:1 mux between 16 requesters. A winner
// is picked in IDLE by rotating priority from ptr, the grant is held until
// release, request drop or MAX_HOLD cycles, and then one IDLE cycle follows.
// The mux output is registered into y with y_vld, one cycle behind si/busy.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : scheduler side of mux_rr_scheduler_if (req/rel/di in,
//              gnt/si/busy/timeout/y/y_vld out)
// Parameter MAX_HOLD: maximum grant length in cycles (1..15).
// ----------------------------------------------------------------------------
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst,
    mux_rr_scheduler_if.slave   bus
);

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    // Rotate req so that bit 0 is requester ptr, take the lowest set bit,
    // then add ptr back to get the absolute index (wraps mod 16).
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [N-1:0]     req,
        input logic [SEL_W-1:0] ptr
    );
        logic [2*N-1:0]   dbl;
        logic [N-1:0]     rot;
        logic [SEL_W-1:0] off;
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        return off + ptr;
    endfunction

    state_e           state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [3:0]       cnt_q;
    logic [N-1:0]     gnt_q;
    logic [SEL_W-1:0] si_q;
    logic             busy_q;
    logic             timeout_q;
    logic             y_q;
    logic             y_vld_q;

    logic [SEL_W-1:0] win_idx_d;
    logic [N-1:0]     win_onehot_d;
    logic             owner_req_d;
    logic             hold_done_d;
    logic             end_d;
    logic             timeout_d;
    logic             mux_y;

    assign win_idx_d = rr_pick(bus.req, ptr_q);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot_d[gi] = (win_idx_d == SEL_W'(gi));
        end
    endgenerate

    // End conditions seen while BUSY; release and request drop both
    // override the hold limit, so timeout only fires when neither is present.
    assign owner_req_d = bus.req[si_q];
    assign hold_done_d = (cnt_q == HOLD_LIM);
    assign end_d       = bus.rel || !owner_req_d || hold_done_d;
    assign timeout_d   = hold_done_d && !bus.rel && owner_req_d;

    mux_16x1 u_mux (
        .d_i (bus.di),
        .s_i (si_q),
        .y_o (mux_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            si_q      <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            y_q       <= 1'b0;
            y_vld_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            // Data path uses the grant registered on the previous edge.
            y_q       <= busy_q ? mux_y : 1'b0;
            y_vld_q   <= busy_q;
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        state_q <= ST_BUSY;
                        gnt_q   <= win_onehot_d;
                        si_q    <= win_idx_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= 4'd1;
                    end
                end
                ST_BUSY: begin
                    if (end_d) begin
                        state_q   <= ST_IDLE;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        ptr_q     <= si_q + 4'd1;
                        timeout_q <= timeout_d;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.si      = si_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
    assign bus.y       = y_q;
    assign bus.y_vld   = y_vld_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_mux_rr_scheduler
// Directed scenarios plus randomized traffic against a cycle-level
// behavioural model of the round-robin scheduler.
// ----------------------------------------------------------------------------
module tb_mux_rr_scheduler;

    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_rr_scheduler_if bus ();

    mux_rr_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_ptr, m_si, m_cnt;
    bit m_busy, m_to, m_y, m_yv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input logic [15:0] rq, input bit rl, input logic [15:0] d);
        if (r) begin
            m_ptr = 0; m_si = 0; m_cnt = 0;
            m_busy = 0; m_to = 0; m_y = 0; m_yv = 0;
        end else begin
            m_y  = m_busy ? d[m_si] : 1'b0;
            m_yv = m_busy;
            m_to = 0;
            if (!m_busy) begin
                if (rq != 16'h0) begin
                    for (int k = 0; k < 16; k++) begin
                        if (rq[(m_ptr + k) % 16]) begin
                            m_si = (m_ptr + k) % 16;
                            break;
                        end
                    end
                    m_busy = 1;
                    m_cnt  = 1;
                    $display("grant req=%04h ptr=%0d -> requester %0d", rq, m_ptr, m_si);
                end
            end else if (rl || !rq[m_si] || m_cnt == MAX_HOLD) begin
                m_to   = !rl && rq[m_si] && (m_cnt == MAX_HOLD);
                m_busy = 0;
                m_ptr  = (m_si + 1) % 16;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic step(input bit r, input logic [15:0] rq, input bit rl, input logic [15:0] d);
        logic [15:0] eg;
        rst = r; bus.req = rq; bus.rel = rl; bus.di = d;
        @(posedge clk);
        model_edge(r, rq, rl, d);
        #1;
        eg = m_busy ? (16'h1 << m_si) : 16'h0;
        chk("gnt",     32'(bus.gnt),     32'(eg));
        chk("si",      32'(bus.si),      32'(m_si));
        chk("busy",    32'(bus.busy),    32'(m_busy));
        chk("timeout", 32'(bus.timeout), 32'(m_to));
        chk("y",       32'(bus.y),       32'(m_y));
        chk("y_vld",   32'(bus.y_vld),   32'(m_yv));
    endtask

    task automatic do_reset();
        step(1, 16'h0, 0, 16'h0);
        step(1, 16'h0, 0, 16'h0);
    endtask

    initial begin
        int grants;
        int bcnt, tcnt;
        bit prev;
        int wrap_exp [3] = '{15, 0, 1};

        rst = 1'b1; bus.req = '0; bus.rel = 1'b0; bus.di = '0;

        // Reset state
        do_reset();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_si",   32'(bus.si),   32'd0);

        // Reset mid-grant: requester 5, reset on third busy cycle
        step(0, 16'h0020, 0, 16'hFFFF);
        step(0, 16'h0020, 0, 16'hFFFF);
        step(0, 16'h0020, 0, 16'hFFFF);
        chk("mid_busy3", 32'(bus.si), 32'd5);
        step(1, 16'h0020, 0, 16'hFFFF);
        chk("mid_rst_busy",  32'(bus.busy),  32'd0);
        chk("mid_rst_gnt",   32'(bus.gnt),   32'd0);
        chk("mid_rst_y_vld", 32'(bus.y_vld), 32'd0);
        step(0, 16'h0021, 0, 16'h0);
        chk("mid_regrant_si",  32'(bus.si),  32'd0);
        chk("mid_regrant_gnt", 32'(bus.gnt), 32'd1);

        // Rotation: all requesting, release on each first busy cycle
        do_reset();
        grants = 0; prev = 0;
        for (int c = 0; c < 60 && grants < 17; c++) begin
            step(0, 16'hFFFF, m_busy, 16'($urandom));
            if (bus.busy && !prev) begin
                chk("rot_si", 32'(bus.si), 32'(grants % 16));
                grants++;
            end
            prev = bus.busy;
        end
        chk("rot_count", 32'(grants), 32'd17);

        // Wrap-around: move ptr to 14, then requesters 0, 1, 15
        do_reset();
        step(0, 16'h2000, 0, 16'h0);
        step(0, 16'h2000, 1, 16'h0);
        grants = 0; prev = 0;
        for (int c = 0; c < 20 && grants < 3; c++) begin
            step(0, 16'h8003, m_busy, 16'h0);
            if (bus.busy && !prev) begin
                chk("wrap_si", 32'(bus.si), 32'(wrap_exp[grants]));
                grants++;
            end
            prev = bus.busy;
        end
        chk("wrap_count", 32'(grants), 32'd3);

        // Timeout: single requester holds for MAX_HOLD cycles
        step(0, 16'h0, 0, 16'h0);
        step(0, 16'h0, 0, 16'h0);
        bcnt = 0; tcnt = 0;
        for (int c = 0; c < MAX_HOLD + 1; c++) begin
            step(0, 16'h0010, 0, 16'h0010);
            bcnt += int'(bus.busy);
            tcnt += int'(bus.timeout);
        end
        chk("to_busy_len", 32'(bcnt), 32'(MAX_HOLD));
        chk("to_pulses",   32'(tcnt), 32'd1);
        chk("to_last",     32'(bus.timeout), 32'd1);
        step(0, 16'h0010, 0, 16'h0010);
        chk("to_regrant_busy", 32'(bus.busy), 32'd1);
        chk("to_regrant_si",   32'(bus.si),   32'd4);
        // Variant: release on the last allowed cycle suppresses timeout
        bcnt = 1; tcnt = 0;
        for (int c = 0; c < 20 && bus.busy; c++) begin
            step(0, 16'h0010, (m_busy && m_cnt == MAX_HOLD), 16'h0);
            bcnt += int'(bus.busy);
            tcnt += int'(bus.timeout);
        end
        chk("rel_busy_len", 32'(bcnt), 32'(MAX_HOLD));
        chk("rel_pulses",   32'(tcnt), 32'd0);

        // Request drop and data path
        step(0, 16'h0, 0, 16'h0);
        step(0, 16'h0, 0, 16'h0);
        step(0, 16'h0200, 0, 16'h0200);
        chk("drop_si", 32'(bus.si), 32'd9);
        step(0, 16'h0200, 0, 16'h0200);
        chk("drop_y1", 32'({bus.y, bus.y_vld}), 32'b11);
        step(0, 16'h0200, 0, 16'h0000);
        chk("drop_y0", 32'({bus.y, bus.y_vld}), 32'b01);
        step(0, 16'h0000, 0, 16'h0200);
        chk("drop_end", 32'({bus.busy, bus.y_vld}), 32'b01);
        step(0, 16'h0000, 0, 16'h0200);
        chk("drop_after", 32'({bus.y, bus.y_vld}), 32'b00);

        // Idle immunity: ptr is 10 now; rel toggling must not disturb it
        for (int c = 0; c < 10; c++) begin
            step(0, 16'h0, c[0], 16'($urandom));
            chk("idle_flags", 32'({bus.busy, bus.timeout, bus.y_vld}), 32'd0);
            chk("idle_gnt",   32'(bus.gnt), 32'd0);
        end
        step(0, 16'hFFFF, 0, 16'h0);
        chk("idle_ptr", 32'(bus.si), 32'd10);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] rq;
            rq = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 7) == 0) rq = 16'h0;
            step(($urandom_range(0, 199) == 0), rq, ($urandom_range(0, 3) == 0), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
